// File: rtl/miner_ctrl.sv
// Nonce-search controller driving a sha256 double-hash core; loads the 76 fixed header bytes and reports the first winning nonce.
// Define MINER_HASH_STREAM_EN to stream the winning hash out byte-serially; otherwise a match goes straight to DONE.
module miner_ctrl #(
   parameter int HDR_BYTES = 76
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   input  logic         go,
   input  logic         abort,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [7:0]   zbits,
   output logic         busy,
   output logic         found,
   output logic         exhausted,
   output logic [31:0]  nonce_out,
   output logic         out_valid,
   output logic [7:0]   out_data,
   input  logic         out_ready,
   output logic         sha_start,
   output logic [639:0] sha_block,
   input  logic [255:0] sha_hash,
   input  logic         sha_done
);

`ifdef MINER_HASH_STREAM_EN
   localparam bit STREAM = 1'b1;
`else
   localparam bit STREAM = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, READY, START, WAIT, CHECK, FOUND, DONE, DRAIN} state_t;

   state_t         state;
   logic [6:0]     byte_cnt;
   logic [31:0]    nonce;
   logic [31:0]    nonce_last;
   logic [7:0]     zbits_q;
   logic [255:0]   hash_q;
   logic [7:0]     data_q;
   logic           done_q;
   logic           done_rise;
   logic [9:0]     hdr_idx;
   logic [4:0]     nxt_byte;
   logic [7:0]     out_idx;
   logic [255:0]   hash_rev;
   logic           hit;

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [255:0] brev256(input logic [255:0] v);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[8*i +: 8] = v[255-8*i -: 8];
      end
      return r;
   endfunction

   assign done_rise = sha_done & ~done_q;
   assign hdr_idx   = 10'd639 - {byte_cnt, 3'b000};
   assign nxt_byte  = byte_cnt[4:0] + 5'd1;
   assign out_idx   = {~nxt_byte, 3'b111};

   // Difficulty test: the top zbits of the byte-reversed digest must all be zero.
   assign hash_rev  = brev256(hash_q);
   assign hit       = (zbits_q == 8'd0) || ((hash_rev >> (9'd256 - {1'b0, zbits_q})) == '0);

   assign in_ready  = (state == IDLE) & ~rst;
   assign out_valid = STREAM && (state == FOUND);
   assign out_data  = STREAM ? data_q : 8'd0;

   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= sha_done;
   end

   // A WAIT abort must still see the core finish unless that finish is happening right now.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         nonce      <= '0;
         nonce_last <= '0;
         zbits_q    <= '0;
         hash_q     <= '0;
         data_q     <= '0;
         busy       <= 1'b0;
         found      <= 1'b0;
         exhausted  <= 1'b0;
         nonce_out  <= '0;
         sha_start  <= 1'b0;
         sha_block  <= '0;
      end else if (abort && state != IDLE) begin
         state     <= (state == WAIT && !done_rise) ? DRAIN : IDLE;
         busy      <= (state == WAIT && !done_rise);
         found     <= 1'b0;
         exhausted <= 1'b0;
         nonce_out <= '0;
         byte_cnt  <= '0;
         data_q    <= '0;
         sha_start <= 1'b0;
      end else begin
         sha_start <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sha_block[hdr_idx -: 8] <= in_data;
                  if (byte_cnt == 7'(HDR_BYTES - 1)) begin
                     byte_cnt <= '0;
                     state    <= READY;
                  end else begin
                     byte_cnt <= byte_cnt + 7'd1;
                  end
               end
            end
            READY, DONE: begin
               if (go) begin
                  nonce           <= nonce_start;
                  nonce_last      <= nonce_end;
                  zbits_q         <= zbits;
                  found           <= 1'b0;
                  exhausted       <= 1'b0;
                  sha_block[31:0] <= bswap32(nonce_start);
                  sha_start       <= 1'b1;
                  busy            <= 1'b1;
                  state           <= START;
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (done_rise) begin
                  hash_q <= sha_hash;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               if (hit) begin
                  found     <= 1'b1;
                  nonce_out <= nonce;
                  if (STREAM) begin
                     byte_cnt <= '0;
                     data_q   <= hash_q[255:248];
                     state    <= FOUND;
                  end else begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end
               end else if (nonce == nonce_last) begin
                  exhausted <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  nonce           <= nonce + 32'd1;
                  sha_block[31:0] <= bswap32(nonce + 32'd1);
                  sha_start       <= 1'b1;
                  state           <= START;
               end
            end
            FOUND: begin
               if (out_ready) begin
                  if (byte_cnt[4:0] == 5'd31) begin
                     byte_cnt <= '0;
                     data_q   <= '0;
                     busy     <= 1'b0;
                     state    <= DONE;
                  end else begin
                     byte_cnt <= byte_cnt + 7'd1;
                     data_q   <= hash_q[out_idx -: 8];
                  end
               end
            end
            DRAIN: begin
               if (done_rise) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miner_ctrl.sv
// Directed bench for miner_ctrl with a fixed-latency stub standing in for the sha256 core.
module tb_miner_ctrl;

   localparam int CORE_LAT = 4;
   localparam logic [607:0] GEN_HDR = 608'h0100000000000000000000000000000000000000000000000000000000000000000000003ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a29ab5f49ffff001d;
   localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = 8'd0;
   logic         in_ready;
   logic         go = 1'b0;
   logic         abort = 1'b0;
   logic [31:0]  nonce_start = 32'd0;
   logic [31:0]  nonce_end = 32'd0;
   logic [7:0]   zbits = 8'd0;
   logic         busy;
   logic         found;
   logic         exhausted;
   logic [31:0]  nonce_out;
   logic         out_valid;
   logic [7:0]   out_data;
   logic         out_ready = 1'b1;
   logic         sha_start;
   logic [639:0] sha_block;
   logic [255:0] sha_hash;
   logic         sha_done;

   int checks = 0;
   int failures = 0;
   int cycleNo = 0;
   int lastStart = 0;
   int startCount = 0;
   int coreCnt = 0;
   logic [31:0] startLog [0:63];

   miner_ctrl #(.HDR_BYTES(76)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .go(go), .abort(abort),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .zbits(zbits),
      .busy(busy), .found(found), .exhausted(exhausted), .nonce_out(nonce_out),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .sha_start(sha_start), .sha_block(sha_block),
      .sha_hash(sha_hash), .sha_done(sha_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleNo <= cycleNo + 1;

   // Stub core: done pulses CORE_LAT cycles after start; only the genesis nonce yields the genesis digest.
   always @(posedge clk) begin
      if (rst) begin
         coreCnt  <= 0;
         sha_done <= 1'b0;
         sha_hash <= '0;
      end else begin
         sha_done <= (coreCnt == 1);
         if (coreCnt != 0) coreCnt <= coreCnt - 1;
         if (sha_start) begin
            coreCnt    <= CORE_LAT - 1;
            sha_hash   <= (sha_block[31:0] == 32'h1DAC2B7C) ? GEN_HASH : '1;
            lastStart  <= cycleNo;
            startCount <= startCount + 1;
            if (startCount < 64) startLog[startCount] <= sha_block[31:0];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [639:0] got, input logic [639:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic loadHeader();
      logic [607:0] hdr;
      hdr = GEN_HDR;
      for (int k = 0; k < 76; k++) begin
         in_valid = 1'b1;
         in_data  = hdr[607-8*k -: 8];
         @(negedge clk);
      end
      in_data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e, input logic [7:0] z);
      nonce_start = s;
      nonce_end   = e;
      zbits       = z;
      go          = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic waitResult(output int lat, output bit sawValid);
      lat = -1;
      sawValid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
         if (found || exhausted) begin
            lat = cycleNo - lastStart;
            break;
         end
      end
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      checkOutput(tag, 640'(busy), 640'd0);
   endtask

   task automatic collectStream(input bit toggle, output logic [255:0] got, output int n);
      got = '0;
      n = 0;
      for (int i = 0; i < 200 && n < 32; i++) begin
         if (out_valid && out_ready) begin
            got = {got[247:0], out_data};
            n++;
         end
         if (n < 32) begin
            if (toggle) out_ready = ~out_ready;
            @(negedge clk);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int base;
      int lat;
      int n;
      bit sawValid;
      logic [255:0] got;

      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 640'(in_ready), 640'd0);
      checkOutput("rst_busy", 640'(busy), 640'd0);
      checkOutput("rst_found", 640'(found), 640'd0);
      checkOutput("rst_exhausted", 640'(exhausted), 640'd0);
      checkOutput("rst_nonce_out", 640'(nonce_out), 640'd0);
      checkOutput("rst_out_valid", 640'(out_valid), 640'd0);
      checkOutput("rst_out_data", 640'(out_data), 640'd0);
      checkOutput("rst_sha_start", 640'(sha_start), 640'd0);
      checkOutput("rst_sha_block", sha_block, 640'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 640'(in_ready), 640'd1);
      checkOutput("post_rst_busy", 640'(busy), 640'd0);

      base = startCount;
      applyStimulus(32'd0, 32'd3, 8'd0);
      @(negedge clk);
      checkOutput("idle_go_busy", 640'(busy), 640'd0);
      checkOutput("idle_go_pulses", 640'(startCount - base), 640'd0);

      loadHeader();
      checkOutput("ready_in_ready", 640'(in_ready), 640'd0);
      checkOutput("header_bytes", 640'(sha_block[639:32]), 640'(GEN_HDR));

      // Genesis hit, three nonces tried.
      base = startCount;
      out_ready = 1'b1;
      applyStimulus(32'h7C2BAC1B, 32'h7C2BAC20, 8'd32);
      waitResult(lat, sawValid);
      checkOutput("gen_found", 640'(found), 640'd1);
      checkOutput("gen_exhausted", 640'(exhausted), 640'd0);
      checkOutput("gen_nonce_out", 640'(nonce_out), 640'h7C2BAC1D);
      checkOutput("gen_pulses", 640'(startCount - base), 640'd3);
      checkOutput("gen_third_block", 640'(startLog[base+2]), 640'h1DAC2B7C);
      checkOutput("gen_latency", 640'(lat), 640'(CORE_LAT + 2));
`ifdef MINER_HASH_STREAM_EN
      checkOutput("gen_first_valid", 640'(out_valid), 640'd1);
      collectStream(1'b0, got, n);
      checkOutput("gen_stream_count", 640'(n), 640'd32);
      checkOutput("gen_stream_bytes", 640'(got), 640'(GEN_HASH));
      checkOutput("gen_done_busy", 640'(busy), 640'd0);
`else
      checkOutput("gen_busy", 640'(busy), 640'd0);
      checkOutput("gen_no_stream", 640'(out_valid | sawValid), 640'd0);
`endif

      // Same header from DONE, range misses the winner.
      base = startCount;
      applyStimulus(32'h7C2BAC1E, 32'h7C2BAC20, 8'd32);
      waitResult(lat, sawValid);
      checkOutput("exh_exhausted", 640'(exhausted), 640'd1);
      checkOutput("exh_found", 640'(found), 640'd0);
      checkOutput("exh_pulses", 640'(startCount - base), 640'd3);
      checkOutput("exh_no_valid", 640'(sawValid | out_valid), 640'd0);
      checkOutput("exh_busy", 640'(busy), 640'd0);

      base = startCount;
      applyStimulus(32'd5, 32'd9, 8'd0);
      waitResult(lat, sawValid);
      checkOutput("z0_found", 640'(found), 640'd1);
      checkOutput("z0_nonce_out", 640'(nonce_out), 640'd5);
      waitIdle("z0_idle");
      checkOutput("z0_pulses", 640'(startCount - base), 640'd1);

      // Nonce wrap with an unreachable difficulty.
      base = startCount;
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 8'd255);
      waitResult(lat, sawValid);
      checkOutput("wrap_pulses", 640'(startCount - base), 640'd3);
      checkOutput("wrap_block0", 640'(startLog[base]), 640'hFFFFFFFF);
      checkOutput("wrap_block1", 640'(startLog[base+1]), 640'h00000000);
      checkOutput("wrap_block2", 640'(startLog[base+2]), 640'h01000000);
      checkOutput("wrap_exhausted", 640'(exhausted), 640'd1);

`ifdef MINER_HASH_STREAM_EN
      out_ready = 1'b0;
      applyStimulus(32'h7C2BAC1D, 32'h7C2BAC1D, 8'd32);
      waitResult(lat, sawValid);
      checkOutput("bp_found", 640'(found), 640'd1);
      collectStream(1'b1, got, n);
      checkOutput("bp_stream_count", 640'(n), 640'd32);
      checkOutput("bp_stream_bytes", 640'(got), 640'(GEN_HASH));
      checkOutput("bp_done_busy", 640'(busy), 640'd0);
      checkOutput("bp_done_valid", 640'(out_valid), 640'd0);
`endif

      // Abort while the core is busy: drain until its done edge, then IDLE.
      base = startCount;
      applyStimulus(32'd0, 32'd10, 8'd255);
      checkOutput("abort_start_pulse", 640'(sha_start), 640'd1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      checkOutput("abort_drain_cycles", 640'(n), 640'(CORE_LAT - 1));
      checkOutput("abort_in_ready", 640'(in_ready), 640'd1);
      checkOutput("abort_found", 640'(found), 640'd0);
      repeat (10) @(negedge clk);
      checkOutput("abort_pulses", 640'(startCount - base), 640'd1);

      applyStimulus(32'd0, 32'd1, 8'd0);
      @(negedge clk);
      checkOutput("abort_header_gone", 640'(busy), 640'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
